// File: rtl/prog_updown_counter_pkg.sv
// Shared constants and helpers for the programmable up/down counter.
// Mode/direction encodings plus a ceil-log2 used to size the prescaler.
package counter_pkg;

    localparam int   CNT_MODE_WRAP = 0;
    localparam int   CNT_MODE_SAT  = 1;
    localparam logic CNT_DIR_UP    = 1'b1;
    localparam logic CNT_DIR_DN    = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_updown_counter_if.sv
// Control/status bundle of the programmable up/down counter.
// The master drives controls; the slave (counter) drives status.
interface prog_updown_counter_if #(
    parameter int WIDTH = 8
);

    logic             clr;
    logic             enable;
    logic             up_dn;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf_flag;
    logic             at_max;
    logic             at_zero;

    modport master (
        output clr, enable, up_dn,
        output load_en, load_val, clr_flags,
        input  count, tc, ovf_flag,
        input  at_max, at_zero
    );

    modport slave (
        input  clr, enable, up_dn,
        input  load_en, load_val, clr_flags,
        output count, tc, ovf_flag,
        output at_max, at_zero
    );

endinterface

// File: rtl/prog_updown_counter_enable_prescaler.sv
// Divides the count enable: one tick per PRESCALE enabled cycles.
// Phase holds while enable is low; restart returns it to zero.
module enable_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int PW_RAW = clog2(PRESCALE);
    localparam int PW = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = enable & (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (restart || tick) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable-modulus up/down counter with load, clear, prescaled
// enable, wrap/saturate ends, terminal-count pulse and sticky overflow.
module prog_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int          PRESCALE = 1,
    parameter int          SATURATE = 0
) (
    input logic               clk,
    input logic               rst_n,
    prog_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam bit SAT = (SATURATE == CNT_MODE_SAT);

    initial begin
        if (WIDTH < 2)
            $error("WIDTH must be >= 2");
        if (MAX_VAL < 1 ||
            longint'(MAX_VAL) >= (longint'(1) << WIDTH))
            $error("MAX_VAL out of range");
        if (PRESCALE < 1)
            $error("PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ld_val;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             restart;
    logic             up;
    logic             at_end;

    assign restart = bus.clr | bus.load_en;

    enable_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .enable (bus.enable),
        .tick   (tick)
    );

    assign up     = (bus.up_dn == CNT_DIR_UP);
    assign ld_val = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    assign at_end = up ? (cnt_q == MAXV) : (cnt_q == '0);

    // Range end is tested before stepping, so +1/-1 never overflows.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.load_en) begin
            cnt_d = ld_val;
        end else if (tick) begin
            tc_d = at_end;
            if (!at_end)
                cnt_d = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            else if (!SAT)
                cnt_d = up ? '0 : MAXV;
        end
        ovf_d = tc_d | (ovf_q & ~bus.clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.count    = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.at_max   = (cnt_q == MAXV);
    assign bus.at_zero  = (cnt_q == '0);

endmodule
